paillier_result_arbiter: RTL and testbench

Round-robin drain scheduler for the per-engine result FIFOs that sit behind the BLOCK_COUNT Paillier engines. Watches each FIFO's fill count, grants one FIFO at a time, pops a fixed-length burst from it and presents the words as a single valid/ready stream tagged with source index and burst-last, for the AXI-FULL write engine. Also supports a flush mode that drains partial bursts at end of job.

---
 rtl/paillier_result_arbiter.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_paillier_result_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paillier_result_arbiter.sv
// ---------------------------------------------------------------------------
// paillier_result_arbiter
//
// Drains the per-engine result FIFOs that sit behind the Paillier engines. Each
// FIFO's fill count is watched. One FIFO at a time is granted in round-robin
// order, and a fixed-length burst is popped from it. The popped words leave as
// one valid/ready stream. Each word carries its source index, and the final
// word of a burst is marked. The stream feeds the AXI write engine.
//
// While flush is high, a FIFO holding a partial burst is also eligible. A burst
// granted from such a FIFO carries only the words that are present.
//
// Optional feature:
//   PAILLIER_RESULT_CNT_EN  when this macro is defined, words_sent counts the
//                           accepted beats. It wraps at 2^32 and is cleared
//                           only by rst. When the macro is not defined,
//                           words_sent is tied to 0.
//
// Ports
//   clk, rst     single clock; synchronous active-high reset
//   enable       arbitration allowed; only looked at in IDLE
//   flush        level; partially filled FIFOs become eligible
//   rd_cnt       packed fill counts, FIFO i at slice i ($clog2(N)+1 bits each)
//   rd_rdy       one-hot pop strobe towards the FIFOs
//   rd_dout      packed FIFO read data; valid one cycle after rd_rdy
//   m_data/m_valid/m_ready/m_last/m_src   output stream with tags
//   busy         high whenever a burst is in progress
//   words_sent   count of accepted beats (see the optional feature above)
//
// BLOCK_COUNT must be at least 2. BURST_LEN must be in 1..N.
// ---------------------------------------------------------------------------
module paillier_result_arbiter #(
    parameter int BLOCK_COUNT = 29,
    parameter int K           = 128,
    parameter int N           = 32,
    parameter int BURST_LEN   = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic                                  flush,
    input  logic [BLOCK_COUNT*($clog2(N)+1)-1:0]  rd_cnt,
    output logic [BLOCK_COUNT-1:0]                rd_rdy,
    input  logic [BLOCK_COUNT*K-1:0]              rd_dout,
    output logic [K-1:0]                          m_data,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic                                  m_last,
    output logic [$clog2(BLOCK_COUNT)-1:0]        m_src,
    output logic                                  busy,
    output logic [31:0]                           words_sent
);

    localparam int CW = $clog2(N) + 1;
    localparam int SW = $clog2(BLOCK_COUNT);
    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_TAIL  = 2'd2
    } state_t;

    state_t          state_q, state_d;

    logic [SW-1:0]   grant_q, grant_d;
    logic [SW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   len_q, len_d;
    logic [CW-1:0]   pop_cnt_q, pop_cnt_d;
    logic [CW-1:0]   push_cnt_q, push_cnt_d;
    logic            inflight_q, inflight_d;

    // Two-entry output buffer, written in order and read in order.
    logic [K-1:0]    buf_data_q [2];
    logic [K-1:0]    buf_data_d [2];
    logic [1:0]      buf_last_q, buf_last_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      occ_q, occ_d;

    logic [CW-1:0]   cnt_arr  [BLOCK_COUNT];
    logic [K-1:0]    dout_arr [BLOCK_COUNT];
    logic [BLOCK_COUNT-1:0] eligible;

    logic            found;
    logic [SW-1:0]   pick;
    logic [CW-1:0]   pick_cnt;
    logic [CW-1:0]   pick_len;
    logic            start;
    logic            pop;
    logic            last_pop;
    logic            accept;
    logic [2:0]      pending;

    // -----------------------------------------------------------------------
    // Per-FIFO unpacking, eligibility and pop strobes
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < BLOCK_COUNT; gi++) begin : g_fifo
            assign cnt_arr[gi]  = rd_cnt[gi*CW +: CW];
            assign dout_arr[gi] = rd_dout[gi*K +: K];
            assign eligible[gi] = (cnt_arr[gi] >= BURST_LEN_C) ||
                                  (flush && (cnt_arr[gi] != '0));
            assign rd_rdy[gi]   = pop && (grant_q == SW'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin search. It starts just above the last granted index and
    // wraps around.
    // -----------------------------------------------------------------------
    always_comb begin : rr_search
        int            idx;
        logic [SW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int off = 1; off <= BLOCK_COUNT; off++) begin
            idx = int'(last_grant_q) + off;
            if (idx >= BLOCK_COUNT) begin
                idx = idx - BLOCK_COUNT;
            end
            cand = SW'(idx);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // A normally eligible FIFO holds at least BURST_LEN words, so min() gives
    // BURST_LEN for it. A flush-only FIFO gives its partial count.
    assign pick_cnt = cnt_arr[pick];
    assign pick_len = (pick_cnt >= BURST_LEN_C) ? BURST_LEN_C : pick_cnt;

    assign m_valid  = (occ_q != 2'd0);
    assign accept   = m_valid && m_ready;
    assign m_data   = buf_data_q[rd_ptr_q];
    assign m_last   = m_valid && buf_last_q[rd_ptr_q];
    assign m_src    = grant_q;

    // A pop is allowed only if, after this cycle's accept, the buffered words
    // plus the word in flight stay below 2. This leaves room when the popped
    // word lands.
    assign pending  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, accept};
    assign last_pop = (pop_cnt_q == (len_q - CW'(1)));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable && found)  state_d = S_DRAIN;
            S_DRAIN: if (pop && last_pop)  state_d = S_TAIL;
            S_TAIL:  if (accept && m_last) state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy  = (state_q != S_IDLE);
        start = (state_q == S_IDLE) && enable && found;
        pop   = (state_q == S_DRAIN) && (pending < 3'd2);
    end

    // -----------------------------------------------------------------------
    // Burst bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        pop_cnt_d    = pop_cnt_q;
        push_cnt_d   = push_cnt_q;
        inflight_d   = pop;

        if (start) begin
            grant_d    = pick;
            len_d      = pick_len;
            pop_cnt_d  = '0;
            push_cnt_d = '0;
        end
        if (pop) begin
            pop_cnt_d = pop_cnt_q + CW'(1);
        end
        if (inflight_q) begin
            push_cnt_d = push_cnt_q + CW'(1);
        end
        if ((state_q == S_TAIL) && accept && m_last) begin
            last_grant_d = grant_q;
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer
    // -----------------------------------------------------------------------
    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, accept};

        // The read data arrives one cycle after the pop. It is written with
        // the last-word flag that its position in the burst implies.
        if (inflight_q) begin
            buf_data_d[wr_ptr_q] = dout_arr[grant_q];
            buf_last_d[wr_ptr_q] = (push_cnt_q == (len_q - CW'(1)));
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (accept) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q       <= '0;
            last_grant_q  <= SW'(BLOCK_COUNT - 1);
            len_q         <= '0;
            pop_cnt_q     <= '0;
            push_cnt_q    <= '0;
            inflight_q    <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q    <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= '0;
        end else begin
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            len_q         <= len_d;
            pop_cnt_q     <= pop_cnt_d;
            push_cnt_q    <= push_cnt_d;
            inflight_q    <= inflight_d;
            buf_data_q[0] <= buf_data_d[0];
            buf_data_q[1] <= buf_data_d[1];
            buf_last_q    <= buf_last_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
        end
    end

    // -----------------------------------------------------------------------
    // Accepted-beat counter
    // -----------------------------------------------------------------------
`ifdef PAILLIER_RESULT_CNT_EN
    logic [31:0] words_sent_q, words_sent_d;

    always_comb begin
        words_sent_d = words_sent_q;
        if (accept) begin
            words_sent_d = words_sent_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_sent_q <= '0;
        end else begin
            words_sent_q <= words_sent_d;
        end
    end

    assign words_sent = words_sent_q;
`else
    assign words_sent = 32'd0;
`endif

endmodule

// File: tb/tb_paillier_result_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for paillier_result_arbiter. It uses directed bursts against a
// simple FIFO read-data model. Each FIFO returns pattern(index, sequence).
// ---------------------------------------------------------------------------
module tb_paillier_result_arbiter;

    localparam int BC = 29;
    localparam int K  = 128;
    localparam int N  = 32;
    localparam int BL = 32;
    localparam int CW = 6;
    localparam int SW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              flush;
    logic [BC*CW-1:0]  rd_cnt;
    logic [BC-1:0]     rd_rdy;
    logic [BC*K-1:0]   rd_dout = '0;
    logic [K-1:0]      m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [SW-1:0]     m_src;
    logic              busy;
    logic [31:0]       words_sent;

    int n_checks  = 0;
    int n_pass    = 0;
    int total_acc = 0;
    int mseq [BC] = '{default: 0};
    int eseq [BC] = '{default: 0};

    always #5 clk = ~clk;

    paillier_result_arbiter #(
        .BLOCK_COUNT (BC),
        .K           (K),
        .N           (N),
        .BURST_LEN   (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .flush      (flush),
        .rd_cnt     (rd_cnt),
        .rd_rdy     (rd_rdy),
        .rd_dout    (rd_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .m_src      (m_src),
        .busy       (busy),
        .words_sent (words_sent)
    );

    function automatic logic [K-1:0] pattern(input int i, input int s);
        return {8'(i), 24'hA5C3E1, 32'(s), ~32'(s), 32'(i * 97 + s)};
    endfunction

    // FIFO read-data model: the data is registered one cycle after a pop.
    always @(posedge clk) begin
        for (int i = 0; i < BC; i++) begin
            if (rd_rdy[i]) begin
                rd_dout[i*K +: K] <= pattern(i, mseq[i]);
                mseq[i]           <= mseq[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cnt(input int i, input int v);
        rd_cnt[i*CW +: CW] = CW'(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_rdy"}, rd_rdy, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_src"}, m_src, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_words_sent"}, words_sent, 0);
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        enable  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        rd_cnt  = '0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        total_acc = 0;
        for (int i = 0; i < BC; i++) eseq[i] = mseq[i];
    endtask

    // This task is called at a negedge. When exp_pop_cyc > 0, the first pop
    // must come exp_pop_cyc cycles later, and the first m_valid two cycles
    // after that. ready_mode 0 holds m_ready high. ready_mode 1 drives m_ready
    // with the pattern 1,0,0 repeating.
    task automatic run_burst(input int src, input int len, input int ready_mode,
                             input int exp_pop_cyc, input string name);
        int cyc = 0, pops = 0, beats = 0, first_pop = -1, first_valid = -1;
        int data_bad = 0, src_bad = 0, last_bad = 0, hold_bad = 0, rdy_bad = 0, max_ahead = 0;
        logic done = 1'b0;
        logic prev_stall = 1'b0;
        logic [K-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic [SW-1:0] prev_src = '0;
        logic [BC-1:0] onehot = '0;
        onehot[src] = 1'b1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 1);
            #1;
            if (rd_rdy != '0) begin
                pops++;
                if (first_pop < 0) begin
                    first_pop = cyc;
                    set_cnt(src, 0);
                end
                if (rd_rdy !== onehot) rdy_bad++;
            end
            if (prev_stall && (m_data !== prev_data || m_last !== prev_last || m_src !== prev_src))
                hold_bad++;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                beats++;
                total_acc++;
                if (m_data !== pattern(src, eseq[src])) data_bad++;
                eseq[src]++;
                if (m_src !== SW'(src)) src_bad++;
                if (m_last !== (beats == len)) last_bad++;
                if (m_last) done = 1'b1;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_src   = m_src;
            if (pops - beats > max_ahead) max_ahead = pops - beats;
        end
        m_ready = 1'b1;
        check({name, "_done"}, done, 1);
        check({name, "_beats"}, beats, len);
        check({name, "_pops"}, pops, len);
        check({name, "_data_errs"}, data_bad, 0);
        check({name, "_src_errs"}, src_bad, 0);
        check({name, "_last_errs"}, last_bad, 0);
        check({name, "_hold_errs"}, hold_bad, 0);
        check({name, "_rdrdy_errs"}, rdy_bad, 0);
        check({name, "_over3_ahead"}, (max_ahead > 3), 0);
        if (exp_pop_cyc > 0) begin
            check({name, "_first_pop"}, first_pop, exp_pop_cyc);
            check({name, "_first_valid"}, first_valid, exp_pop_cyc + 2);
        end
        $display("burst %s src=%0d len=%0d beats=%0d pops=%0d first_pop=%0d max_ahead=%0d",
                 name, src, len, beats, pops, first_pop, max_ahead);
    endtask

    initial begin
        int busy_seen;
        int rdy_seen;
        int acc;
        int exp_ws;

        // Check the reset values.
        rst     = 1'b1;
        enable  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        rd_cnt  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single full burst from FIFO 3.
        enable  = 1'b1;
        m_ready = 1'b1;
        set_cnt(3, 32);
        run_burst(3, 32, 0, 1, "fifo3");

        // Round robin: 0, 5, 28, then wrap to 0 and 5.
        reset_dut();
        enable  = 1'b1;
        m_ready = 1'b1;
        set_cnt(0, 32);
        set_cnt(5, 32);
        set_cnt(28, 32);
        run_burst(0, 32, 0, 1, "rr0");
        run_burst(5, 32, 0, 2, "rr5");
        set_cnt(0, 32);
        set_cnt(5, 32);
        run_burst(28, 32, 0, 2, "rr28");
        run_burst(0, 32, 0, 2, "rr0_wrap");
        run_burst(5, 32, 0, 2, "rr5_wrap");

        // Back-pressure with m_ready toggling.
        @(negedge clk);
        set_cnt(12, 32);
        run_burst(12, 32, 1, 1, "toggle12");

        // A partial FIFO without flush is never granted.
        @(negedge clk);
        flush = 1'b0;
        set_cnt(7, 5);
        busy_seen = 0;
        rdy_seen  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (rd_rdy != '0) rdy_seen++;
        end
        check("noflush_busy", busy_seen, 0);
        check("noflush_rdrdy", rdy_seen, 0);
        $display("idle  noflush fifo7 cnt=5 busy_cycles=%0d pop_cycles=%0d", busy_seen, rdy_seen);

        // With flush, the same FIFO drains as a 5-word burst.
        flush = 1'b1;
        run_burst(7, 5, 0, 1, "flush7");
        flush = 1'b0;

        // Beat counter since the last reset.
        @(negedge clk);
`ifdef PAILLIER_RESULT_CNT_EN
        exp_ws = total_acc;
`else
        exp_ws = 0;
`endif
        check("words_sent_mid", words_sent, exp_ws);

        // Reset in the middle of a burst, after its tenth beat.
        set_cnt(10, 32);
        m_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 100 && acc < 10; c++) begin
            @(negedge clk);
            #1;
            if (rd_rdy[10]) set_cnt(10, 0);
            if (m_valid && m_ready) acc++;
            if (acc == 10) rst = 1'b1;
        end
        check("midreset_beats", acc, 10);
        @(negedge clk);
        check_reset_outputs("midreset");
        rst       = 1'b0;
        total_acc = 0;
        for (int i = 0; i < BC; i++) eseq[i] = mseq[i];

        // Index 0 has priority again, ahead of 28.
        set_cnt(0, 32);
        set_cnt(28, 32);
        run_burst(0, 32, 0, 1, "prio0");
        run_burst(28, 32, 0, 2, "next28");
        @(negedge clk);
`ifdef PAILLIER_RESULT_CNT_EN
        exp_ws = 64;
`else
        exp_ws = 0;
`endif
        check("words_sent_64", words_sent, exp_ws);
        check("idle_after", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
